medidor_distancia: RTL
======================

# medidor_distancia

Ultrasonic ranging front end (HC-SR04 style). It sits directly upstream of the barrier circuit and feeds its `distancia_cm` input.
- Periodically fires a trigger pulse and times the returning echo.
- Converts the echo width to whole centimetres.
- Presents a registered 8-bit distance with a one-cycle valid strobe.

## Interface
Parameters:
- `TRIG_CYCLES`, default 500: trigger high width in clk cycles (10 µs at 50 MHz).
- `CYCLES_PER_CM`, default 2900: echo-high cycles per centimetre (58 µs at 50 MHz).
- `ECHO_TIMEOUT`, default 1_500_000: max cycles in WAIT_ECHO before giving up.
- `IDLE_CYCLES`, default 3_000_000: gap between measurements (60 ms).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `echo_in`  in  1  raw echo pin; asynchronous to `clk`.
- `trig_out`  out  1  trigger pulse to the sensor.
- `distancia_cm`  out  8  last measured distance in cm; 255 means none or out of range.
- `valid`  out  1  one-cycle strobe when `distancia_cm` is updated.
- `erro`  out  1  1 if the last measurement timed out; updated together with `valid`.

## Operation
- `echo_in` passes through a 2-flop synchronizer; all logic uses the synchronized `echo_s`.
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
- IDLE: count `IDLE_CYCLES` cycles, then go to TRIG.
- TRIG: `trig_out`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_ECHO.
- WAIT_ECHO: wait for a rising edge of `echo_s` (previous 0, current 1).
  - On the edge, go to MEASURE, counting that cycle as the first high cycle.
  - After `ECHO_TIMEOUT` cycles with no edge, go to DONE with result 255 and erro=1.
  - An echo already high on entry does not count; it must fall and rise again.
- MEASURE: a prescaler counts `echo_s`-high cycles.
  - Each time the prescaler hits `CYCLES_PER_CM`, it wraps to 0 and the cm counter increments.
  - When `echo_s` falls, go to DONE with result = cm counter, i.e. floor(high_cycles / `CYCLES_PER_CM`).
  - If the cm counter reaches 255, saturate: go to DONE immediately with result 255, erro=0.
- DONE, single cycle:
  - Register the result into `distancia_cm`, set `erro`, pulse `valid`.
  - Clear the counters, then go to IDLE.
- Width rules:
  - Counters are sized with $clog2 of their parameter.
  - The cm counter is 8 bits and never wraps.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE and all counters clear.
  - Outputs: `trig_out`=0, `valid`=0, `erro`=0, `distancia_cm`=8'd255, so downstream sees "no object".
  - Reset mid-measurement aborts with no `valid` pulse.
- The first trigger rises `IDLE_CYCLES` cycles after the first clk edge with `rst_n`=1.
- `trig_out` is registered, glitch-free, and exactly `TRIG_CYCLES` cycles wide.
- Echo edges reach the FSM 2 cycles late through the synchronizer. Both edges are delayed equally, so a pin pulse of N cycles (synchronous stimulus) measures as N high cycles.
- Latency, echo fall to `valid`: `valid`=1 on the 3rd clk edge after the edge that first samples `echo_in` low.
- Latency, saturation to `valid`: 1 cycle after the cm counter reaches 255.
- `distancia_cm` and `erro` change only on the same edge `valid` rises, and are held otherwise.
- Measurement period is IDLE + TRIG + echo phase + 1 cycle. There is no overlap, and no new trigger fires while in WAIT_ECHO or MEASURE.

## Structure
- Package `medidor_pkg` holds:
  - the state encoding (IDLE, TRIG, WAIT_ECHO, MEASURE, DONE);
  - the default parameter constants;
  - `DIST_INVALIDA` = 8'd255.
- Sub-module `sincronizador` provides the 2-flop synchronizer, with `clk`, `rst_n`, `d`, `q` ports and reset value 0.
- The FSM, prescaler and cm counter stay in `medidor_distancia`.

## Test plan
All scenarios use TRIG_CYCLES=4, CYCLES_PER_CM=10, ECHO_TIMEOUT=100, IDLE_CYCLES=20, with `echo_in` driven synchronously to `clk`.
- Reset then release -> `distancia_cm`=255, `valid`=0, `erro`=0; `trig_out` rises 20 cycles after release and stays high 4 cycles.
- Echo high 125 cycles after trigger -> `valid` pulse 3 cycles after fall, `distancia_cm`=12, `erro`=0.
- Echo width 9 -> 0; width 10 -> 1; width 2549 -> 254. Checks floor and prescaler wrap.
- No echo -> `valid` 100 cycles after trigger falls, `distancia_cm`=255, `erro`=1; next trigger follows after 20 idle cycles.
- Echo held high 3000 cycles -> result 255 with `erro`=0 after 2550 high cycles. The following measurement, with echo still high, times out: `erro`=1.
- `rst_n` pulsed low mid-MEASURE -> outputs return to reset values immediately, no `valid`; a fresh cycle starts 20 cycles after release.

Source files
------------

// File: rtl/medidor_pkg.sv
// Shared state encoding, default timing constants and the "no object"
// distance code for the ultrasonic ranging front end.
package medidor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } estado_t;

  localparam int TRIG_CYCLES_DEF   = 500;
  localparam int CYCLES_PER_CM_DEF = 2900;
  localparam int ECHO_TIMEOUT_DEF  = 1_500_000;
  localparam int IDLE_CYCLES_DEF   = 3_000_000;

  localparam logic [7:0] DIST_INVALIDA = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer bringing the asynchronous echo pin into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/medidor_distancia.sv
// HC-SR04 style ranging front end: fires periodic triggers, times the echo
// and reports the distance in whole centimetres with a one-cycle valid strobe.
module medidor_distancia
  import medidor_pkg::*;
#(
  parameter int TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int CYCLES_PER_CM = CYCLES_PER_CM_DEF,
  parameter int ECHO_TIMEOUT  = ECHO_TIMEOUT_DEF,
  parameter int IDLE_CYCLES   = IDLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       echo_in,
  output logic       trig_out,
  output logic [7:0] distancia_cm,
  output logic       valid,
  output logic       erro
);

  // One phase counter serves IDLE, TRIG and WAIT_ECHO, so it is sized for the longest.
  localparam int CNT_MAX = max3(TRIG_CYCLES, ECHO_TIMEOUT, IDLE_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(CYCLES_PER_CM + 1);

  localparam logic [CW-1:0] IDLE_FIM    = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_FIM    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_FIM = CW'(ECHO_TIMEOUT - 1);
  localparam logic [PW-1:0] PRESC_FIM   = PW'(CYCLES_PER_CM);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cm_q, cm_d;
  logic [7:0]    res_q, res_d;
  logic          err_q, err_d;
  logic          trig_q, trig_d;
  logic [7:0]    dist_q, dist_d;
  logic          erro_q, erro_d;
  logic          valid_q, valid_d;
  logic          echo_ant_q;

  logic          echo_s;
  logic          echo_sobe;
  logic [PW-1:0] presc_inc;
  logic          presc_hit;
  logic [7:0]    cm_inc;

  sincronizador u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo_in),
    .q     (echo_s)
  );

  // An echo already high when WAIT_ECHO is entered shows echo_ant_q=1, so it never counts.
  assign echo_sobe = echo_s & ~echo_ant_q;
  assign presc_inc = presc_q + PW'(1);
  assign presc_hit = (presc_inc == PRESC_FIM);
  assign cm_inc    = cm_q + 8'd1;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    cm_d     = cm_q;
    res_d    = res_q;
    err_d    = err_q;
    trig_d   = trig_q;
    dist_d   = dist_q;
    erro_d   = erro_q;
    valid_d  = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (cnt_q == IDLE_FIM) begin
          estado_d = TRIG;
          cnt_d    = '0;
          trig_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_FIM) begin
          estado_d = WAIT_ECHO;
          cnt_d    = '0;
          trig_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_ECHO: begin
        if (echo_sobe) begin
          estado_d = MEASURE;
          cnt_d    = '0;
          presc_d  = presc_hit ? '0 : presc_inc;
          cm_d     = presc_hit ? cm_inc : cm_q;
        end else if (cnt_q == TIMEOUT_FIM) begin
          estado_d = DONE;
          res_d    = DIST_INVALIDA;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          estado_d = DONE;
          res_d    = cm_q;
          err_d    = 1'b0;
        end else begin
          presc_d = presc_hit ? '0 : presc_inc;
          cm_d    = presc_hit ? cm_inc : cm_q;
          if (presc_hit && (cm_inc == DIST_INVALIDA)) begin
            estado_d = DONE;
            res_d    = DIST_INVALIDA;
            err_d    = 1'b0;
          end
        end
      end
      DONE: begin
        dist_d   = res_q;
        erro_d   = err_q;
        valid_d  = 1'b1;
        cnt_d    = '0;
        presc_d  = '0;
        cm_d     = '0;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      cnt_q      <= '0;
      presc_q    <= '0;
      cm_q       <= '0;
      res_q      <= DIST_INVALIDA;
      err_q      <= 1'b0;
      trig_q     <= 1'b0;
      dist_q     <= DIST_INVALIDA;
      erro_q     <= 1'b0;
      valid_q    <= 1'b0;
      echo_ant_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      cm_q       <= cm_d;
      res_q      <= res_d;
      err_q      <= err_d;
      trig_q     <= trig_d;
      dist_q     <= dist_d;
      erro_q     <= erro_d;
      valid_q    <= valid_d;
      echo_ant_q <= echo_s;
    end
  end

  assign trig_out     = trig_q;
  assign distancia_cm = dist_q;
  assign valid        = valid_q;
  assign erro         = erro_q;

endmodule
